// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder block: default index width and a
// ceiling-log2 helper for sizing index fields from vector widths.
package encoder_pkg;

  // Default index width; the request vector is 2**LOGS_DEFAULT bits wide.
  localparam int LOGS_DEFAULT = 4;

  // Ceiling log2: clog2(1)=0, clog2(10)=4, clog2(16)=4.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
      end
    end
    return result;
  endfunction

endpackage : encoder_pkg

// File: rtl/encoder_if.sv
// Request/result bundle for the encoder. The master drives the request
// vector and its qualifier; the slave (the encoder) returns the registered
// index and flags.
interface encoder_if #(
  parameter int logS = encoder_pkg::LOGS_DEFAULT
) ();

  logic [2**logS-1:0] in;
  logic               in_valid;
  logic [logS-1:0]    out;
  logic               out_valid;
  logic               zero;
  logic               multi;

  modport master (
    output in,
    output in_valid,
    input  out,
    input  out_valid,
    input  zero,
    input  multi
  );

  modport slave (
    input  in,
    input  in_valid,
    output out,
    output out_valid,
    output zero,
    output multi
  );

endinterface : encoder_if

// File: rtl/encoder_core.sv
// Combinational priority encoder: returns the lowest set index of vec_i,
// a flag for an all-zero vector and, when ENCODER_ONEHOT_CHECK_EN is
// defined, a flag for more than one bit set (tied low otherwise).
module encoder_core
  import encoder_pkg::*;
#(
  parameter int logS = LOGS_DEFAULT
) (
  input  logic [2**logS-1:0] vec_i,
  output logic [logS-1:0]    idx_o,
  output logic               zero_o,
  output logic               multi_o
);

  localparam int W = 2**logS;

  // Scan from the top bit down so the lowest set bit is the last to write idx_o.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = logS'(i);
      end
    end
  end

  assign zero_o = ~|vec_i;

`ifdef ENCODER_ONEHOT_CHECK_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  logic [W-1:0] vec_minus_one;
  assign vec_minus_one = vec_i - {{(W-1){1'b0}}, 1'b1};
  assign multi_o       = |(vec_i & vec_minus_one);
`else
  assign multi_o = 1'b0;
`endif

endmodule : encoder_core

// File: rtl/encoder.sv
// Registered one-hot to binary encoder with one cycle of latency.
// Optional population check is enabled by defining ENCODER_ONEHOT_CHECK_EN;
// without it the multi flag is constant zero.
module encoder
  import encoder_pkg::*;
#(
  parameter int logS = LOGS_DEFAULT
) (
  input logic     clk,
  input logic     rst_n,
  encoder_if.slave bus
);

  logic [logS-1:0] out_d;
  logic            zero_d;
  logic            multi_d;

  logic [logS-1:0] out_q;
  logic            zero_q;
  logic            multi_q;
  logic            valid_q;

  encoder_core #(
    .logS (logS)
  ) u_core (
    .vec_i   (bus.in),
    .idx_o   (out_d),
    .zero_o  (zero_d),
    .multi_o (multi_d)
  );

  // Capture results on valid input; hold them across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q   <= out_d;
        zero_q  <= zero_d;
        multi_q <= multi_d;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.multi     = multi_q;
  assign bus.out_valid = valid_q;

endmodule : encoder

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder (logS=4). Stimulus pushes hand-computed
// expectations; a negedge monitor pops one per out_valid and compares.
module tb_encoder;

  localparam int LOGS = 4;

  typedef struct {
    logic [LOGS-1:0] out;
    logic            zero;
    logic            multi;
    string           name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  encoder_if #(.logS(LOGS)) bus ();

  encoder #(.logS(LOGS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; expectation is queued only if the edge will accept it.
  task automatic drive(input logic [15:0] vec, input logic vld,
                       input logic [LOGS-1:0] e_out, input logic e_zero,
                       input logic e_multi_chk, input string name);
    exp_t e;
    bus.in       = vec;
    bus.in_valid = vld;
    if (vld && rst_n) begin
      e.out  = e_out;
      e.zero = e_zero;
`ifdef ENCODER_ONEHOT_CHECK_EN
      e.multi = e_multi_chk;
`else
      e.multi = 1'b0;
`endif
      e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each presented result against the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_valid: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_out"},   32'(bus.out),   32'(e.out));
        chk({e.name, "_zero"},  32'(bus.zero),  32'(e.zero));
        chk({e.name, "_multi"}, 32'(bus.multi), 32'(e.multi));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.in       = '0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out",       32'(bus.out),       32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_zero",      32'(bus.zero),      32'd0);
    chk("rst_multi",     32'(bus.multi),     32'd0);
    rst_n = 1'b1;

    drive(16'h0001, 1'b1, 4'd0,  1'b0, 1'b0, "bit0");
    drive(16'h8000, 1'b1, 4'd15, 1'b0, 1'b0, "bit15");
    drive(16'h0000, 1'b0, 4'd0,  1'b0, 1'b0, "idle");
    chk("hold_out_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_out",       32'(bus.out),       32'd15);
    chk("hold_zero",      32'(bus.zero),      32'd0);

    drive(16'h0000, 1'b1, 4'd0, 1'b1, 1'b0, "zero_vec");
    drive(16'h0028, 1'b1, 4'd3, 1'b0, 1'b1, "multi_0028");
    drive(16'hFFFF, 1'b1, 4'd0, 1'b0, 1'b1, "multi_ffff");
    drive(16'hC000, 1'b1, 4'd14, 1'b0, 1'b1, "multi_c000");

    for (int i = 0; i < 16; i++) begin
      drive(16'(1) << i, 1'b1, 4'(i), 1'b0, 1'b0, "sweep");
    end
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, "idle");

    // Reset coincides with a valid request; that request must be discarded.
    rst_n = 1'b0;
    drive(16'h0100, 1'b1, 4'd8, 1'b0, 1'b0, "discard");
    chk("rst2_out",       32'(bus.out),       32'd0);
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_zero",      32'(bus.zero),      32'd0);
    chk("rst2_multi",     32'(bus.multi),     32'd0);
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, "idle");
    drive(16'h0004, 1'b1, 4'd2, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 5; i++) begin
      drive(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, "drain");
    end
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_encoder

// File: doc/encoder.md
ENCODER -- requirements
Module: encoder

Interface
REQ-001 SHALL have parameter logS, default 4, giving the output index width; the input width is 2**logS bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in, input, 2**logS bits: one-hot request vector (bit i set = index i requested).
REQ-005 SHALL have port in_valid, input, 1 bit: qualifies in for the current cycle.
REQ-006 SHALL have port out, output, logS bits: registered binary index of the selected set bit.
REQ-007 SHALL have port out_valid, output, 1 bit: out, zero and multi are meaningful this cycle.
REQ-008 SHALL have port zero, output, 1 bit: registered flag that the captured vector had no bit set.
REQ-009 SHALL have port multi, output, 1 bit: registered flag that the captured vector had more than one bit set.

Function
REQ-010 SHALL have a latency of exactly 1 cycle: if in_valid=1 at edge k, then out, zero, multi and out_valid=1 reflect that in after edge k.
REQ-011 SHALL drive out_valid=0 after any edge where in_valid=0; out, zero and multi SHALL then hold their previous values.
REQ-012 SHALL, for a one-hot in with bit i set, set out=i, zero=0 and multi=0.
REQ-013 SHALL, for in=0, set out=0 and zero=1.
REQ-014 SHALL, for a multi-hot in, select the lowest set index as out (priority to bit 0) and set zero=0.
REQ-015 SHALL use index arithmetic of exactly logS bits; bit 2**logS-1 SHALL encode to all-ones, with no overflow or wrap.
REQ-016 SHALL be fully pipelined, accepting a new vector every cycle with no backpressure and no ready signal.
REQ-017 SHALL make back-to-back valid inputs produce back-to-back valid outputs in order.

Reset
REQ-018 SHALL, on any edge where rst_n=0, set out=0, out_valid=0, zero=0 and multi=0, regardless of in_valid.
REQ-019 SHALL give reset priority over a simultaneous valid input and discard that input; the first output after release SHALL come from the first in_valid=1 sampled with rst_n=1.

Configuration
REQ-020 SHALL, when macro ENCODER_ONEHOT_CHECK_EN is defined, include the population check and drive multi as specified in REQ-009 and REQ-012.
REQ-021 SHALL, when ENCODER_ONEHOT_CHECK_EN is undefined, omit the check logic and tie multi to 0; all other behaviour is unchanged, including the lowest-index priority of REQ-014.

Structure
REQ-022 SHALL place a ceiling-log2 function (log2(1)=0, log2(10)=4, log2(16)=4) in shared package encoder_pkg, together with the default logS constant.
REQ-023 SHALL have one combinational sub-module, encoder_core: in -> index, zero and multi (lowest-set-bit priority); encoder adds only the output registers and the valid register.

Verification
REQ-024 SHALL cover: logS=4, in=16'h0001 with in_valid=1 -> next cycle out=0, out_valid=1, zero=0, multi=0.
REQ-025 SHALL cover: in=16'h8000 with in_valid=1 -> out=15, out_valid=1, zero=0; then in_valid=0 -> out_valid=0 and out still 15.
REQ-026 SHALL cover: in=16'h0000 with in_valid=1 -> out=0, zero=1, multi=0.
REQ-027 SHALL cover: in=16'h0028 with in_valid=1 -> out=3; multi=1 with ENCODER_ONEHOT_CHECK_EN defined, multi=0 without it.
REQ-028 SHALL cover: a sweep of every single-hot vector (bits 0..15, one per cycle) -> out tracks the bit index, lagged by one cycle, with out_valid=1 throughout.
REQ-029 SHALL cover: rst_n=0 on the same edge as in=16'h0100 with in_valid=1 -> all outputs 0 after that edge; after release, in=16'h0004 -> out=2.
